// File: rtl/reg_pkg.sv
// Shared register map, CTRL bit positions and Q_STAT layout for reg_mc.
package reg_pkg;

    // Word addresses of the global registers
    localparam logic [31:0] ADDR_CTRL     = 32'h00;
    localparam logic [31:0] ADDR_STAT     = 32'h01;
    localparam logic [31:0] ADDR_IRQ_MASK = 32'h02;
    localparam logic [31:0] ADDR_SEC_HI   = 32'h03;
    localparam logic [31:0] ADDR_SEC_LO   = 32'h04;
    localparam logic [31:0] ADDR_NS_HI    = 32'h05;
    localparam logic [31:0] ADDR_NS_LO    = 32'h06;
    localparam logic [31:0] ADDR_PER_HI   = 32'h07;
    localparam logic [31:0] ADDR_PER_LO   = 32'h08;
    localparam logic [31:0] ADDR_ACC_HI   = 32'h09;
    localparam logic [31:0] ADDR_ACC_LO   = 32'h0A;
    localparam logic [31:0] ADDR_ADJ_DATA = 32'h0B;
    localparam logic [31:0] ADDR_ADJP_HI  = 32'h0C;
    localparam logic [31:0] ADDR_ADJP_LO  = 32'h0D;
    localparam logic [31:0] ADDR_QBASE    = 32'h10;

    // Word offsets inside a 4-word channel window
    localparam logic [1:0] QOFF_STAT = 2'd0;
    localparam logic [1:0] QOFF_HI   = 2'd1;
    localparam logic [1:0] QOFF_LO   = 2'd2;

    // CTRL write bits
    localparam int CTRL_TIME_LD   = 0;
    localparam int CTRL_PERIOD_LD = 1;
    localparam int CTRL_ADJ_LD    = 2;
    localparam int CTRL_Q_RST     = 3;
    localparam int CTRL_SNAP      = 4;

    // Q_STAT fields
    localparam int QSTAT_CNT_W = 8;
    localparam int QSTAT_UDF   = 8;

    // Pack a channel status word; everything outside the fields reads 0
    function automatic logic [31:0] qstat_word(input logic [QSTAT_CNT_W-1:0] cnt,
                                               input logic udf);
        logic [31:0] w;
        w = '0;
        w[QSTAT_CNT_W-1:0] = cnt;
        w[QSTAT_UDF] = udf;
        return w;
    endfunction

endpackage

// File: rtl/reg_mc_if.sv
// Register access bus between a host and reg_mc.
interface reg_mc_if #(
    parameter int ADDR_W = 6
);
    logic              wr_in;
    logic              rd_in;
    logic [ADDR_W-1:0] addr_in;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              rd_vld;

    modport master (
        output wr_in, rd_in, addr_in, data_in,
        input  data_out, rd_vld
    );

    modport slave (
        input  wr_in, rd_in, addr_in, data_in,
        output data_out, rd_vld
    );
endinterface

// File: rtl/reg_qch.sv
// One TSU queue channel: head-entry latch, sticky underflow flag and pop strobe.
module reg_qch
    import reg_pkg::*;
#(
    parameter int Q_W = 56
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_q_rst,
    input  logic                   i_hi_rd,
    input  logic                   i_stat_rd,
    input  logic [QSTAT_CNT_W-1:0] i_cnt,
    input  logic [Q_W-1:0]         i_head,
    output logic                   o_rd_en,
    output logic [31:0]            o_stat,
    output logic [31:0]            o_hi,
    output logic [31:0]            o_lo
);

    logic [Q_W-1:0] r_entry;
    logic           r_udf;
    logic           w_nonempty;
    logic           w_pop;
    logic [Q_W-1:0] w_entry_nxt;

    assign w_nonempty = |i_cnt;
    assign w_pop      = i_hi_rd && w_nonempty;

    // Next entry value: q_rst wins, a pop loads the show-ahead head, else hold
    always_comb begin
        w_entry_nxt = r_entry;
        if (i_q_rst)
            w_entry_nxt = '0;
        else if (w_pop)
            w_entry_nxt = i_head;
    end

    // Entry latch, underflow flag and pop pulse (pulse lines up with rd_vld)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_entry <= '0;
            r_udf   <= 1'b0;
            o_rd_en <= 1'b0;
        end else begin
            r_entry <= w_entry_nxt;
            o_rd_en <= w_pop;
            if (i_q_rst)
                r_udf <= 1'b0;
            else if (i_hi_rd && !w_nonempty)
                r_udf <= 1'b1;
            else if (i_stat_rd)
                r_udf <= 1'b0;
        end
    end

    // HI returns the entry being popped; an empty queue returns 0
    assign o_hi   = w_pop ? 32'(w_entry_nxt >> 32) : 32'd0;
    assign o_lo   = r_entry[31:0];
    assign o_stat = qstat_word(i_cnt, r_udf);

endmodule

// File: rtl/reg_mc.sv
// Register block for the RTC / TSU: load registers, command pulses,
// time snapshot and per-channel queue readout.
module reg_mc
    import reg_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 6,
    parameter int Q_W    = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_mc_if.slave               bus,
    output logic                  irq,
    output logic                  time_ld,
    output logic                  period_ld,
    output logic                  adj_ld,
    output logic                  q_rst,
    output logic [37:0]           time_reg_ns_out,
    output logic [47:0]           time_reg_sec_out,
    output logic [39:0]           period_out,
    output logic [37:0]           time_acc_modulo_out,
    output logic [31:0]           adj_ld_data_out,
    output logic [39:0]           period_adj_out,
    input  logic [37:0]           time_reg_ns_in,
    input  logic [47:0]           time_reg_sec_in,
    output logic [NUM_CH-1:0]     q_rd_en,
    input  logic [8*NUM_CH-1:0]   q_rd_stat,
    input  logic [Q_W*NUM_CH-1:0] q_rd_data
);

    // Access qualification: the first edge after reset release is ignored
    logic        r_rdy;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_addr;
    logic        w_ctrl_wr;

    // Holding registers
    logic [15:0]       r_sec_hi;
    logic [31:0]       r_sec_lo;
    logic [5:0]        r_ns_hi;
    logic [31:0]       r_ns_lo;
    logic [7:0]        r_per_hi;
    logic [31:0]       r_per_lo;
    logic [5:0]        r_acc_hi;
    logic [31:0]       r_acc_lo;
    logic [31:0]       r_adj_data;
    logic [7:0]        r_adjp_hi;
    logic [31:0]       r_adjp_lo;
    logic [NUM_CH-1:0] r_irq_mask;

    // Snapshot, command pulses, read path
    logic [37:0] r_snap_ns;
    logic [47:0] r_snap_sec;
    logic        r_time_ld;
    logic        r_period_ld;
    logic        r_adj_ld;
    logic        r_q_rst;
    logic [31:0] r_data;
    logic        r_vld;
    logic        r_irq;
    logic [31:0] w_rdata;

    // Channel decode and per-channel views
    logic [31:0]                    w_qoff;
    logic [31:0]                    w_ch_idx;
    logic [1:0]                     w_sub;
    logic                           w_ch_hit;
    logic [NUM_CH-1:0]              w_sel;
    logic [NUM_CH-1:0]              w_nonempty;
    logic [NUM_CH-1:0][7:0]         w_cnt;
    logic [NUM_CH-1:0][Q_W-1:0]     w_head;
    logic [NUM_CH-1:0][31:0]        w_q_stat;
    logic [NUM_CH-1:0][31:0]        w_q_hi;
    logic [NUM_CH-1:0][31:0]        w_q_lo;

    assign w_addr    = 32'(bus.addr_in);
    assign w_wr      = bus.wr_in && r_rdy;
    assign w_rd      = bus.rd_in && r_rdy;
    assign w_ctrl_wr = w_wr && (w_addr == ADDR_CTRL);

    assign w_qoff   = w_addr - ADDR_QBASE;
    assign w_ch_idx = {2'b00, w_qoff[31:2]};
    assign w_sub    = w_qoff[1:0];
    assign w_ch_hit = (w_addr >= ADDR_QBASE) && (w_ch_idx < 32'(NUM_CH));

    assign w_cnt  = q_rd_stat;
    assign w_head = q_rd_data;

    // Block becomes ready one clock after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rdy <= 1'b0;
        else      r_rdy <= 1'b1;
    end

    // Holding register writes; unmapped addresses fall through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sec_hi   <= '0;
            r_sec_lo   <= '0;
            r_ns_hi    <= '0;
            r_ns_lo    <= '0;
            r_per_hi   <= '0;
            r_per_lo   <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_adj_data <= '0;
            r_adjp_hi  <= '0;
            r_adjp_lo  <= '0;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (w_addr)
                ADDR_IRQ_MASK: r_irq_mask <= bus.data_in[NUM_CH-1:0];
                ADDR_SEC_HI:   r_sec_hi   <= bus.data_in[15:0];
                ADDR_SEC_LO:   r_sec_lo   <= bus.data_in;
                ADDR_NS_HI:    r_ns_hi    <= bus.data_in[5:0];
                ADDR_NS_LO:    r_ns_lo    <= bus.data_in;
                ADDR_PER_HI:   r_per_hi   <= bus.data_in[7:0];
                ADDR_PER_LO:   r_per_lo   <= bus.data_in;
                ADDR_ACC_HI:   r_acc_hi   <= bus.data_in[5:0];
                ADDR_ACC_LO:   r_acc_lo   <= bus.data_in;
                ADDR_ADJ_DATA: r_adj_data <= bus.data_in;
                ADDR_ADJP_HI:  r_adjp_hi  <= bus.data_in[7:0];
                ADDR_ADJP_LO:  r_adjp_lo  <= bus.data_in;
                default: ;
            endcase
        end
    end

    // One-cycle command pulses from CTRL writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_time_ld   <= 1'b0;
            r_period_ld <= 1'b0;
            r_adj_ld    <= 1'b0;
            r_q_rst     <= 1'b0;
        end else begin
            r_time_ld   <= w_ctrl_wr && bus.data_in[CTRL_TIME_LD];
            r_period_ld <= w_ctrl_wr && bus.data_in[CTRL_PERIOD_LD];
            r_adj_ld    <= w_ctrl_wr && bus.data_in[CTRL_ADJ_LD];
            r_q_rst     <= w_ctrl_wr && bus.data_in[CTRL_Q_RST];
        end
    end

    // Snapshot ns and sec together on the CTRL snapshot write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_ns  <= '0;
            r_snap_sec <= '0;
        end else if (w_ctrl_wr && bus.data_in[CTRL_SNAP]) begin
            r_snap_ns  <= time_reg_ns_in;
            r_snap_sec <= time_reg_sec_in;
        end
    end

    // Per-channel queue logic
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_sel[c]      = w_ch_hit && (w_ch_idx == 32'(c));
        assign w_nonempty[c] = |w_cnt[c];

        reg_qch #(.Q_W(Q_W)) u_qch (
            .clk       (clk),
            .rst       (rst),
            .i_q_rst   (r_q_rst),
            .i_hi_rd   (w_rd && w_sel[c] && (w_sub == QOFF_HI)),
            .i_stat_rd (w_rd && w_sel[c] && (w_sub == QOFF_STAT)),
            .i_cnt     (w_cnt[c]),
            .i_head    (w_head[c]),
            .o_rd_en   (q_rd_en[c]),
            .o_stat    (w_q_stat[c]),
            .o_hi      (w_q_hi[c]),
            .o_lo      (w_q_lo[c])
        );
    end

    // Read mux; time addresses return the snapshot, not the load values
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_STAT:     w_rdata = 32'(w_nonempty);
            ADDR_IRQ_MASK: w_rdata = 32'(r_irq_mask);
            ADDR_SEC_HI:   w_rdata = 32'(r_snap_sec[47:32]);
            ADDR_SEC_LO:   w_rdata = r_snap_sec[31:0];
            ADDR_NS_HI:    w_rdata = 32'(r_snap_ns[37:32]);
            ADDR_NS_LO:    w_rdata = r_snap_ns[31:0];
            ADDR_PER_HI:   w_rdata = 32'(r_per_hi);
            ADDR_PER_LO:   w_rdata = r_per_lo;
            ADDR_ACC_HI:   w_rdata = 32'(r_acc_hi);
            ADDR_ACC_LO:   w_rdata = r_acc_lo;
            ADDR_ADJ_DATA: w_rdata = r_adj_data;
            ADDR_ADJP_HI:  w_rdata = 32'(r_adjp_hi);
            ADDR_ADJP_LO:  w_rdata = r_adjp_lo;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_sel[c]) begin
                        case (w_sub)
                            QOFF_STAT: w_rdata = w_q_stat[c];
                            QOFF_HI:   w_rdata = w_q_hi[c];
                            QOFF_LO:   w_rdata = w_q_lo[c];
                            default:   w_rdata = '0;
                        endcase
                    end
                end
            end
        endcase
    end

    // Registered read data; zero whenever no read completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_data <= w_rd ? w_rdata : 32'd0;
            r_vld  <= w_rd;
        end
    end

    // Level interrupt from masked non-empty status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_irq <= 1'b0;
        else      r_irq <= |(w_nonempty & r_irq_mask);
    end

    assign bus.data_out        = r_data;
    assign bus.rd_vld          = r_vld;
    assign irq                 = r_irq;
    assign time_ld             = r_time_ld;
    assign period_ld           = r_period_ld;
    assign adj_ld              = r_adj_ld;
    assign q_rst               = r_q_rst;
    assign time_reg_sec_out    = {r_sec_hi, r_sec_lo};
    assign time_reg_ns_out     = {r_ns_hi, r_ns_lo};
    assign period_out          = {r_per_hi, r_per_lo};
    assign time_acc_modulo_out = {r_acc_hi, r_acc_lo};
    assign adj_ld_data_out     = r_adj_data;
    assign period_adj_out      = {r_adjp_hi, r_adjp_lo};

endmodule

// File: tb/tb_reg_mc.sv
// Directed bench for reg_mc: hand-computed vectors through one check task.
module tb_reg_mc;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 6;
    localparam int Q_W    = 56;

    logic clk;
    logic rst;
    logic irq, time_ld, period_ld, adj_ld, q_rst;
    logic [37:0] time_reg_ns_out, time_acc_modulo_out, time_reg_ns_in;
    logic [47:0] time_reg_sec_out, time_reg_sec_in;
    logic [39:0] period_out, period_adj_out;
    logic [31:0] adj_ld_data_out;
    logic [NUM_CH-1:0]     q_rd_en;
    logic [8*NUM_CH-1:0]   q_rd_stat;
    logic [Q_W*NUM_CH-1:0] q_rd_data;

    int n_chk;
    int n_err;

    reg_mc_if #(.ADDR_W(ADDR_W)) bus ();

    reg_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .Q_W(Q_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .irq(irq), .time_ld(time_ld), .period_ld(period_ld), .adj_ld(adj_ld), .q_rst(q_rst),
        .time_reg_ns_out(time_reg_ns_out), .time_reg_sec_out(time_reg_sec_out),
        .period_out(period_out), .time_acc_modulo_out(time_acc_modulo_out),
        .adj_ld_data_out(adj_ld_data_out), .period_adj_out(period_adj_out),
        .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
        .q_rd_en(q_rd_en), .q_rd_stat(q_rd_stat), .q_rd_data(q_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All drives happen 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.wr_in = 1'b1; bus.addr_in = a; bus.data_in = d;
        tick();
        bus.wr_in = 1'b0;
    endtask

    task automatic do_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d,
                         output logic v, output logic [NUM_CH-1:0] qe);
        bus.rd_in = 1'b1; bus.addr_in = a;
        tick();
        bus.rd_in = 1'b0;
        d = bus.data_out; v = bus.rd_vld; qe = q_rd_en;
    endtask

    logic [31:0]       rd;
    logic              vld;
    logic [NUM_CH-1:0] qe;

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b0;
        bus.wr_in = 1'b0; bus.rd_in = 1'b0; bus.addr_in = '0; bus.data_in = '0;
        time_reg_ns_in = '0; time_reg_sec_in = '0; q_rd_stat = '0; q_rd_data = '0;
        repeat (2) tick();
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_rd_vld", bus.rd_vld, 0);
        chk("rst_irq", irq, 0);
        chk("rst_pulses", {time_ld, period_ld, adj_ld, q_rst}, 0);
        chk("rst_q_rd_en", q_rd_en, 0);
        rst = 1'b1;
        repeat (2) tick();

        // Seconds load value and time_ld pulse
        do_wr(6'h03, 32'h0000_1234);
        do_wr(6'h04, 32'h89AB_CDEF);
        chk("sec_out", time_reg_sec_out, 48'h1234_89AB_CDEF);
        do_wr(6'h00, 32'h1);
        chk("time_ld_pulse", {time_ld, period_ld, adj_ld, q_rst}, 4'b1000);
        tick();
        chk("time_ld_drop", time_ld, 0);
        do_rd(6'h03, rd, vld, qe);
        chk("sec_hi_is_snapshot", rd, 0);

        // Several CTRL bits pulse together
        do_wr(6'h00, 32'hE);
        chk("multi_pulse", {time_ld, period_ld, adj_ld, q_rst}, 4'b0111);
        tick();
        chk("multi_pulse_drop", {time_ld, period_ld, adj_ld, q_rst}, 4'b0000);

        // Period with junk in unused high bits
        do_wr(6'h07, 32'h0000_01FF);
        do_wr(6'h08, 32'h1122_3344);
        chk("period_out", period_out, 40'hFF_1122_3344);
        do_rd(6'h07, rd, vld, qe);
        chk("period_hi_rd", rd, 32'h0000_00FF);
        chk("period_hi_vld", vld, 1);

        // Snapshot: inputs change after the CTRL write
        time_reg_ns_in  = 38'h2A_0000_0001;
        time_reg_sec_in = 48'h0000_5555_6666;
        do_wr(6'h00, 32'h10);
        chk("snap_no_pulse", {time_ld, period_ld, adj_ld, q_rst}, 0);
        time_reg_ns_in  = 38'h3F_FFFF_FFFF;
        time_reg_sec_in = 48'hFFFF_FFFF_FFFF;
        do_rd(6'h05, rd, vld, qe);
        chk("snap_ns_hi", rd, 32'h2A);
        do_rd(6'h06, rd, vld, qe);
        chk("snap_ns_lo", rd, 32'h1);
        do_rd(6'h04, rd, vld, qe);
        chk("snap_sec_lo", rd, 32'h5555_6666);
        do_rd(6'h03, rd, vld, qe);
        chk("snap_sec_hi", rd, 0);

        // Channel 1 pop and repeatable LO read
        q_rd_stat = {8'd3, 8'd0};
        q_rd_data[111:56] = 56'hAB_CDEF_0123_4567;
        do_rd(6'h01, rd, vld, qe);
        chk("stat_ne", rd, 32'h2);
        do_rd(6'h15, rd, vld, qe);
        chk("ch1_hi", rd, 32'h00AB_CDEF);
        chk("ch1_pop", qe, 2'b10);
        chk("ch1_hi_vld", vld, 1);
        q_rd_stat = {8'd2, 8'd0};
        q_rd_data[111:56] = 56'h11_2222_3333_4444;
        tick();
        chk("pop_one_cycle", q_rd_en, 0);
        chk("idle_vld", bus.rd_vld, 0);
        chk("idle_data_zero", bus.data_out, 0);
        do_rd(6'h16, rd, vld, qe);
        chk("ch1_lo_a", rd, 32'h0123_4567);
        chk("ch1_lo_a_nopop", qe, 0);
        do_rd(6'h16, rd, vld, qe);
        chk("ch1_lo_b", rd, 32'h0123_4567);
        chk("ch1_lo_b_nopop", qe, 0);
        do_rd(6'h14, rd, vld, qe);
        chk("ch1_qstat", rd, 32'h2);

        // Channel 0 underflow
        do_rd(6'h11, rd, vld, qe);
        chk("ch0_empty_hi", rd, 0);
        chk("ch0_empty_nopop", qe, 0);
        do_rd(6'h10, rd, vld, qe);
        chk("ch0_udf_set", rd, 32'h100);
        do_rd(6'h10, rd, vld, qe);
        chk("ch0_udf_clr", rd, 0);

        // q_rst clears underflow and entry registers
        do_rd(6'h11, rd, vld, qe);
        do_wr(6'h00, 32'h8);
        chk("q_rst_pulse", q_rst, 1);
        tick();
        do_rd(6'h10, rd, vld, qe);
        chk("q_rst_udf", rd, 0);
        do_rd(6'h16, rd, vld, qe);
        chk("q_rst_entry", rd, 0);

        // Reserved, out-of-range channel and unmapped addresses
        do_rd(6'h13, rd, vld, qe);
        chk("reserved_rd", rd, 0);
        do_rd(6'h18, rd, vld, qe);
        chk("ch2_rd", rd, 0);
        do_wr(6'h0E, 32'hDEAD_BEEF);
        do_rd(6'h0E, rd, vld, qe);
        chk("unmapped_rd", rd, 0);
        do_rd(6'h00, rd, vld, qe);
        chk("ctrl_rd", rd, 0);

        // Interrupt
        q_rd_stat = '0;
        do_wr(6'h02, 32'h2);
        do_rd(6'h02, rd, vld, qe);
        chk("mask_rd", rd, 32'h2);
        chk("irq_low", irq, 0);
        q_rd_stat = {8'd1, 8'd0};
        tick();
        chk("irq_high", irq, 1);
        do_wr(6'h02, 32'h0);
        tick();
        chk("irq_masked", irq, 0);

        // Simultaneous write and read returns the old value
        bus.wr_in = 1'b1; bus.rd_in = 1'b1; bus.addr_in = 6'h02; bus.data_in = 32'h1;
        tick();
        bus.wr_in = 1'b0; bus.rd_in = 1'b0;
        chk("wr_rd_old", bus.data_out, 0);
        do_rd(6'h02, rd, vld, qe);
        chk("wr_rd_new", rd, 32'h1);

        // Reset across a CTRL=0x7 write
        bus.wr_in = 1'b1; bus.addr_in = 6'h00; bus.data_in = 32'h7;
        #2 rst = 1'b0;
        tick();
        chk("rst_mid_pulses", {time_ld, period_ld, adj_ld}, 0);
        #2 rst = 1'b1;
        tick();
        bus.wr_in = 1'b0;
        chk("rst_rel_pulses", {time_ld, period_ld, adj_ld, q_rst}, 0);
        tick();
        chk("rst_rel_pulses2", {time_ld, period_ld, adj_ld, q_rst}, 0);
        chk("rst_sec_out", time_reg_sec_out, 0);
        chk("rst_period_out", period_out, 0);
        chk("rst_outs", {irq, bus.rd_vld, bus.data_out}, 0);
        do_rd(6'h02, rd, vld, qe);
        chk("rst_mask", rd, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_mc.md
REG_MC -- requirements
Module: reg_mc

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 2, number of TSU queue channels (1..8); ADDR_W, default 6, word-address width; Q_W, default 56, queue entry width (33..64).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- wr_in  in  1  write strobe, one cycle per access.
- rd_in  in  1  read strobe, one cycle per access.
- addr_in  in  ADDR_W  word address.
- data_in  in  32  write data.
- data_out  out  32  read data, registered.
- rd_vld  out  1  data_out valid strobe.
- irq  out  1  level interrupt.
- time_ld, period_ld, adj_ld, q_rst  out  1 each  one-cycle command pulses.
- time_reg_ns_out  out  38  ns load value.
- time_reg_sec_out  out  48  sec load value.
- period_out  out  40  rtc period.
- time_acc_modulo_out  out  38  accumulator modulo.
- adj_ld_data_out  out  32  adjust count.
- period_adj_out  out  40  adjust period.
- time_reg_ns_in  in  38  live rtc ns.
- time_reg_sec_in  in  48  live rtc sec.
- q_rd_en  out  NUM_CH  per-channel pop pulse.
- q_rd_stat  in  8*NUM_CH  per-channel fill count; channel c occupies [8c+7:8c].
- q_rd_data  in  Q_W*NUM_CH  per-channel show-ahead head entry.

Function
REQ-003 Address map (word addresses) SHALL be:
- 0x00 CTRL: write 1 to bit0 pulses time_ld, bit1 period_ld, bit2 adj_ld, bit3 q_rst, bit4 triggers a time snapshot; CTRL reads 0.
- 0x01 STAT: read-only, bit c = channel c non-empty.
- 0x02 IRQ_MASK: RW, [NUM_CH-1:0].
- 0x03/0x04 SEC_HI[15:0]/SEC_LO.
- 0x05/0x06 NS_HI[5:0]/NS_LO.
- 0x07/0x08 PERIOD_HI[7:0]/PERIOD_LO.
- 0x09/0x0A ACC_MOD_HI[5:0]/ACC_MOD_LO.
- 0x0B ADJ_DATA.
- 0x0C/0x0D ADJ_PERIOD_HI[7:0]/ADJ_PERIOD_LO.
- 0x10+4c channel c: +0 Q_STAT, +1 Q_DATA_HI, +2 Q_DATA_LO, +3 reserved.
REQ-004 Writes SHALL take effect in the cycle after wr_in; output registers SHALL drive the holding values continuously.
REQ-005 Command pulses SHALL assert for exactly one cycle, the cycle after the CTRL write; several bits set SHALL pulse simultaneously.
REQ-006 Reads SHALL have latency 1: data_out and rd_vld are registered from rd_in; rd_vld is 1 for one cycle.
REQ-007 When rd_vld=0, data_out SHALL be 0.
REQ-008 Unmapped or reserved addresses, and channels >= NUM_CH, SHALL read 0 and ignore writes.
REQ-009 Unused high bits SHALL read 0.
REQ-010 Reads of time addresses 0x03-0x06 SHALL return the snapshot registers, not the load holding registers.
REQ-011 A snapshot SHALL capture time_reg_ns_in and time_reg_sec_in atomically in the cycle after the CTRL bit4 write.
REQ-012 Q_STAT SHALL return: [7:0] fill count; [8] underflow flag (sticky, cleared by the Q_STAT read itself).
REQ-013 A Q_DATA_HI read with count>0 SHALL:
- latch q_rd_data of that channel into a per-channel entry register;
- return entry[Q_W-1:32];
- pulse q_rd_en[c] for one cycle, aligned with rd_vld.
REQ-014 A Q_DATA_HI read with count=0 SHALL return 0, SHALL NOT pulse q_rd_en, and SHALL set underflow.
REQ-015 A Q_DATA_LO read SHALL return latched entry[31:0] with no pop; it is repeatable.
REQ-016 irq SHALL equal |(STAT & IRQ_MASK), registered.
REQ-017 If wr_in and rd_in are both asserted, both SHALL execute; the read returns the pre-write value.
REQ-018 A q_rst pulse SHALL clear all entry registers and underflow flags in the same cycle.

Reset
REQ-019 rst low SHALL asynchronously clear all registers, data_out, rd_vld, irq, pulses, q_rd_en and IRQ_MASK to 0.
REQ-020 Reset deassertion mid-access SHALL discard that access.

Structure
REQ-021 Register address constants, CTRL bit indices and Q_STAT field positions SHALL live in shared package reg_pkg.
REQ-022 Per-channel entry latch, underflow flag and pop logic SHALL be sub-module reg_qch, instantiated NUM_CH times.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Write SEC_HI=0x1234, SEC_LO=0x89ABCDEF, CTRL=0x1 -> time_reg_sec_out=0x123489ABCDEF when time_ld pulses one cycle.
- Drive ns_in=0x2A_0000_0001, write CTRL=0x10, change inputs, read NS_HI/NS_LO -> 0x2A/0x00000001.
- Ch1 count=3, head=0xAB_CDEF_0123_4567; read 0x15 -> 0x00ABCDEF with q_rd_en[1] one cycle; read 0x16 twice -> 0x01234567 both times, no pop.
- Ch0 count=0, read 0x11 -> 0, no pop; read 0x10 -> bit8=1; second read -> bit8=0.
- IRQ_MASK=0x2, ch1 count goes 0->1 -> irq=1 after one cycle; mask=0 -> irq=0.
- Assert rst during a CTRL=0x7 write -> no pulses, all outputs 0.
